// File: rtl/video_pkg.sv
// Shared constants and helpers for the video pixel serialiser.
// Background pixels are all ones; pixel width is limited to 1, 2 or 4 bits.
package video_pkg;

    localparam logic FILL_BIT = 1'b1;

    function automatic bit bppLegal(input int bpp);
        return (bpp == 1) || (bpp == 2) || (bpp == 4);
    endfunction

    function automatic int pixelsPerWord(input int dataWidth, input int bpp);
        return dataWidth / bpp;
    endfunction

endpackage

// File: rtl/video_fifo.sv
// Synchronous word FIFO with registered occupancy level and full/empty flags.
// A push is accepted when full only if a pop happens on the same edge.
module video_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wr_data,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [LVL_W-1:0] level_r;
    logic             do_pop_s;
    logic             do_push_s;

    assign full    = (level_r == LVL_FULL);
    assign empty   = (level_r == {LVL_W{1'b0}});
    assign level   = level_r;
    assign rd_data = mem_r[rd_ptr_r];

    // Qualify requests: pop needs data, push needs room or a same-edge pop.
    always_comb begin
        do_pop_s  = 1'b0;
        do_push_s = 1'b0;
        if (pop && !empty) begin
            do_pop_s = 1'b1;
        end else begin
            do_pop_s = 1'b0;
        end
        if (push && (!full || do_pop_s)) begin
            do_push_s = 1'b1;
        end else begin
            do_push_s = 1'b0;
        end
    end

    // Storage, pointers and level update.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            level_r  <= {LVL_W{1'b0}};
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r] <= wr_data;
                wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   level_r <= level_r + LVL_W'(1);
                2'b01:   level_r <= level_r - LVL_W'(1);
                default: level_r <= level_r;
            endcase
        end
    end

endmodule

// File: rtl/video_shifter.sv
// Video pixel serialiser: captures snooped VRAM words into a FIFO and shifts
// them out as BPP-bit pixels, one pixel every divider+1 clocks while enabled.
module video_shifter
    import video_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int BPP          = 1,
    parameter int DIV_BITS     = 4,
    parameter int FIFO_DEPTH   = 2,
    parameter int LOAD_LATENCY = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          loadStrobe,
    input  logic [DATA_WIDTH-1:0]         loadData,
    input  logic                          enable,
    input  logic [DIV_BITS-1:0]           divider,
    input  logic                          clearFlags,
    output logic [BPP-1:0]                pixelOut,
    output logic [$clog2(FIFO_DEPTH):0]   fifoLevel,
    output logic                          underrun,
    output logic                          overflow
);

    localparam int PPW    = pixelsPerWord(DATA_WIDTH, BPP);
    localparam int LEFT_W = $clog2(PPW + 1);
    localparam int LVL_W  = $clog2(FIFO_DEPTH) + 1;
    localparam logic [LEFT_W-1:0]     LEFT_FULL = LEFT_W'(PPW);
    localparam logic [LEFT_W-1:0]     LEFT_ONE  = LEFT_W'(1);
    localparam logic [DATA_WIDTH-1:0] FILL_WORD = {DATA_WIDTH{FILL_BIT}};
    localparam logic [DATA_WIDTH-1:0] LOW_FILL  = FILL_WORD >> (DATA_WIDTH - BPP);

    if (!bppLegal(BPP) || ((DATA_WIDTH % BPP) != 0) || (FIFO_DEPTH < 2) || (LOAD_LATENCY < 1)) begin : g_bad_param
        $error("video_shifter: illegal parameter combination");
    end

    logic [LOAD_LATENCY-1:0] strobe_pipe_r;
    logic [DIV_BITS-1:0]     cnt_r;
    logic [DIV_BITS-1:0]     cnt_next_s;
    logic [DATA_WIDTH-1:0]   shreg_r;
    logic [DATA_WIDTH-1:0]   shreg_next_s;
    logic [LEFT_W-1:0]       left_r;
    logic [LEFT_W-1:0]       left_next_s;
    logic                    underrun_r;
    logic                    underrun_next_s;
    logic                    overflow_r;
    logic                    overflow_next_s;
    logic                    underrun_set_s;
    logic                    overflow_set_s;
    logic                    capture_s;
    logic                    tick_s;
    logic                    pop_s;
    logic                    fifo_full_s;
    logic                    fifo_empty_s;
    logic [DATA_WIDTH-1:0]   fifo_head_s;
    logic [LVL_W-1:0]        fifo_level_s;

    assign capture_s = strobe_pipe_r[LOAD_LATENCY-1];
    assign tick_s    = enable && (cnt_r == divider);
    assign pop_s     = tick_s && (left_r <= LEFT_ONE) && !fifo_empty_s;

    video_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (capture_s),
        .pop     (pop_s),
        .wr_data (loadData),
        .rd_data (fifo_head_s),
        .full    (fifo_full_s),
        .empty   (fifo_empty_s),
        .level   (fifo_level_s)
    );

    // Pixel timer and shifter next state.
    always_comb begin
        cnt_next_s     = cnt_r;
        shreg_next_s   = shreg_r;
        left_next_s    = left_r;
        underrun_set_s = 1'b0;
        if (!enable) begin
            cnt_next_s   = {DIV_BITS{1'b0}};
            shreg_next_s = FILL_WORD;
            left_next_s  = {LEFT_W{1'b0}};
        end else if (tick_s) begin
            cnt_next_s = {DIV_BITS{1'b0}};
            if (left_r > LEFT_ONE) begin
                shreg_next_s = (shreg_r << BPP) | LOW_FILL;
                left_next_s  = left_r - LEFT_ONE;
            end else if (!fifo_empty_s) begin
                shreg_next_s = fifo_head_s;
                left_next_s  = LEFT_FULL;
            end else begin
                shreg_next_s   = FILL_WORD;
                left_next_s    = {LEFT_W{1'b0}};
                underrun_set_s = 1'b1;
            end
        end else begin
            // Wraps at all ones, which is how a shrunk divider is eventually met.
            cnt_next_s = cnt_r + DIV_BITS'(1);
        end
    end

    // Sticky flags: a set event outranks a simultaneous clear.
    always_comb begin
        overflow_set_s  = capture_s && fifo_full_s && !pop_s;
        underrun_next_s = underrun_r;
        overflow_next_s = overflow_r;
        if (underrun_set_s) begin
            underrun_next_s = 1'b1;
        end else if (clearFlags) begin
            underrun_next_s = 1'b0;
        end else begin
            underrun_next_s = underrun_r;
        end
        if (overflow_set_s) begin
            overflow_next_s = 1'b1;
        end else if (clearFlags) begin
            overflow_next_s = 1'b0;
        end else begin
            overflow_next_s = overflow_r;
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            strobe_pipe_r <= {LOAD_LATENCY{1'b0}};
            cnt_r         <= {DIV_BITS{1'b0}};
            shreg_r       <= FILL_WORD;
            left_r        <= {LEFT_W{1'b0}};
            underrun_r    <= 1'b0;
            overflow_r    <= 1'b0;
        end else begin
            strobe_pipe_r <= (strobe_pipe_r << 1) | LOAD_LATENCY'(loadStrobe);
            cnt_r         <= cnt_next_s;
            shreg_r       <= shreg_next_s;
            left_r        <= left_next_s;
            underrun_r    <= underrun_next_s;
            overflow_r    <= overflow_next_s;
        end
    end

    assign pixelOut  = shreg_r[DATA_WIDTH-1 -: BPP];
    assign fifoLevel = fifo_level_s;
    assign underrun  = underrun_r;
    assign overflow  = overflow_r;

endmodule

// File: tb/tb_video_shifter.sv
// Directed bench for video_shifter: a 1-bpp instance (dut) and a 2-bpp
// instance (dut2) share all inputs; each task checks one scenario.
module tb_video_shifter;

    logic       clk = 1'b0;
    logic       reset;
    logic       loadStrobe;
    logic [7:0] loadData;
    logic       enable;
    logic [3:0] divider;
    logic       clearFlags;

    logic       pixelOut;
    logic [1:0] fifoLevel;
    logic       underrun;
    logic       overflow;
    logic [1:0] pixelOut2;
    logic [1:0] fifoLevel2;
    logic       underrun2;
    logic       overflow2;

    int passCount = 0;
    int checkCount = 0;

    always #5 clk = ~clk;

    video_shifter dut (
        .clk(clk), .reset(reset), .loadStrobe(loadStrobe), .loadData(loadData),
        .enable(enable), .divider(divider), .clearFlags(clearFlags),
        .pixelOut(pixelOut), .fifoLevel(fifoLevel), .underrun(underrun), .overflow(overflow)
    );

    video_shifter #(.BPP(2)) dut2 (
        .clk(clk), .reset(reset), .loadStrobe(loadStrobe), .loadData(loadData),
        .enable(enable), .divider(divider), .clearFlags(clearFlags),
        .pixelOut(pixelOut2), .fifoLevel(fifoLevel2), .underrun(underrun2), .overflow(overflow2)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        enable = 1'b0; loadStrobe = 1'b0; clearFlags = 1'b0; divider = 4'd0; loadData = 8'h00;
        reset = 1'b0;
        step();
        reset = 1'b1;
        step();
    endtask

    task automatic test_reset();
        reset = 1'b0; enable = 1'b0; loadStrobe = 1'b1; clearFlags = 1'b0; divider = 4'd0; loadData = 8'h3C;
        step();
        step();
        checkCount++; if (pixelOut !== 1'b1) $display("FAIL reset_pixel: got %b expected 1", pixelOut); else passCount++;
        checkCount++; if (pixelOut2 !== 2'b11) $display("FAIL reset_pixel2: got %b expected 11", pixelOut2); else passCount++;
        checkCount++; if (fifoLevel !== 2'd0) $display("FAIL reset_level: got %0d expected 0", fifoLevel); else passCount++;
        checkCount++; if ({underrun, overflow} !== 2'b00) $display("FAIL reset_flags: got %b expected 00", {underrun, overflow}); else passCount++;
        loadStrobe = 1'b0;
    endtask

    task automatic test_basic_shift();
        logic [7:0] word;
        word = 8'hA5;
        do_reset();
        enable = 1'b1; divider = 4'd1;
        step();
        loadStrobe = 1'b1;
        step();
        loadStrobe = 1'b0; loadData = word;
        step();
        checkCount++; if (fifoLevel !== 2'd1) $display("FAIL basic_capture_level: got %0d expected 1", fifoLevel); else passCount++;
        for (int k = 0; k < 16; k++) begin
            step();
            checkCount++;
            if (pixelOut !== word[7 - k / 2]) $display("FAIL basic_pixel[%0d]: got %b expected %b", k, pixelOut, word[7 - k / 2]);
            else passCount++;
            clearFlags = (k == 0) ? 1'b1 : 1'b0;
        end
        checkCount++; if (underrun !== 1'b0) $display("FAIL basic_no_underrun: got %b expected 0", underrun); else passCount++;
        step();
        checkCount++; if (underrun !== 1'b1) $display("FAIL basic_underrun: got %b expected 1", underrun); else passCount++;
        checkCount++; if (pixelOut !== 1'b1) $display("FAIL basic_fill: got %b expected 1", pixelOut); else passCount++;
        enable = 1'b0;
    endtask

    task automatic test_multibit();
        logic [1:0] expPix [8];
        expPix = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd2, 2'd1, 2'd0};
        do_reset();
        loadStrobe = 1'b1;
        step();
        loadData = 8'h1B;
        step();
        loadData = 8'hE4; loadStrobe = 1'b0;
        step();
        checkCount++; if (fifoLevel2 !== 2'd2) $display("FAIL multi_level: got %0d expected 2", fifoLevel2); else passCount++;
        enable = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step();
            checkCount++;
            if (pixelOut2 !== expPix[k]) $display("FAIL multi_pixel[%0d]: got %0d expected %0d", k, pixelOut2, expPix[k]);
            else passCount++;
        end
        checkCount++; if (underrun2 !== 1'b0) $display("FAIL multi_no_gap: got underrun %b expected 0", underrun2); else passCount++;
        step();
        checkCount++; if ({underrun2, pixelOut2} !== 3'b111) $display("FAIL multi_end: got %b expected 111", {underrun2, pixelOut2}); else passCount++;
        enable = 1'b0;
    endtask

    task automatic test_overflow();
        logic [7:0] w0;
        logic [7:0] w1;
        w0 = 8'h00; w1 = 8'h00;
        do_reset();
        loadStrobe = 1'b1;
        step();
        loadData = 8'h11;
        step();
        loadData = 8'h22;
        step();
        checkCount++; if ({fifoLevel, overflow} !== 3'b100) $display("FAIL ovf_full: got %b expected 100", {fifoLevel, overflow}); else passCount++;
        loadData = 8'h33; loadStrobe = 1'b0;
        step();
        checkCount++; if (fifoLevel !== 2'd2) $display("FAIL ovf_level: got %0d expected 2", fifoLevel); else passCount++;
        checkCount++; if (overflow !== 1'b1) $display("FAIL ovf_flag: got %b expected 1", overflow); else passCount++;
        enable = 1'b1; divider = 4'd0;
        for (int k = 0; k < 16; k++) begin
            step();
            if (k < 8) w0 = {w0[6:0], pixelOut};
            else w1 = {w1[6:0], pixelOut};
        end
        checkCount++; if (w0 !== 8'h11) $display("FAIL ovf_word0: got %h expected 11", w0); else passCount++;
        checkCount++; if (w1 !== 8'h22) $display("FAIL ovf_word1: got %h expected 22", w1); else passCount++;
        step();
        checkCount++; if ({fifoLevel, underrun} !== 3'b001) $display("FAIL ovf_drained: got %b expected 001", {fifoLevel, underrun}); else passCount++;
        enable = 1'b0;
    endtask

    task automatic test_push_pop_full();
        logic [23:0] stream;
        do_reset();
        loadStrobe = 1'b1;
        step();
        loadData = 8'hAA;
        step();
        loadData = 8'h55;
        step();
        checkCount++; if (fifoLevel !== 2'd2) $display("FAIL pp_pre_level: got %0d expected 2", fifoLevel); else passCount++;
        loadData = 8'hC3; loadStrobe = 1'b0; enable = 1'b1; divider = 4'd0;
        step();
        checkCount++; if (fifoLevel !== 2'd2) $display("FAIL pp_level: got %0d expected 2", fifoLevel); else passCount++;
        checkCount++; if (overflow !== 1'b0) $display("FAIL pp_overflow: got %b expected 0", overflow); else passCount++;
        stream = {23'd0, pixelOut};
        for (int k = 1; k < 24; k++) begin
            step();
            stream = {stream[22:0], pixelOut};
        end
        checkCount++; if (stream !== 24'hAA55C3) $display("FAIL pp_stream: got %h expected aa55c3", stream); else passCount++;
        enable = 1'b0;
    endtask

    task automatic test_reset_and_clear();
        do_reset();
        loadStrobe = 1'b1;
        step();
        loadData = 8'h00;
        step();
        loadStrobe = 1'b0;
        step();
        enable = 1'b1;
        step();
        checkCount++; if ({pixelOut, fifoLevel} !== 3'b001) $display("FAIL rst_pre: got %b expected 001", {pixelOut, fifoLevel}); else passCount++;
        #2 reset = 1'b0;
        #1;
        checkCount++; if (pixelOut !== 1'b1) $display("FAIL rst_async_pixel: got %b expected 1", pixelOut); else passCount++;
        checkCount++; if (fifoLevel !== 2'd0) $display("FAIL rst_async_level: got %0d expected 0", fifoLevel); else passCount++;
        reset = 1'b1;
        step();
        checkCount++; if (underrun !== 1'b1) $display("FAIL clr_underrun_set: got %b expected 1", underrun); else passCount++;
        enable = 1'b0; clearFlags = 1'b1;
        step();
        checkCount++; if (underrun !== 1'b0) $display("FAIL clr_cleared: got %b expected 0", underrun); else passCount++;
        enable = 1'b1;
        step();
        checkCount++; if (underrun !== 1'b1) $display("FAIL clr_set_wins: got %b expected 1", underrun); else passCount++;
        clearFlags = 1'b0; enable = 1'b0;
        step();
        checkCount++; if (underrun !== 1'b1) $display("FAIL clr_sticky: got %b expected 1", underrun); else passCount++;
    endtask

    task automatic test_divider_change();
        logic [13:0] expBits;
        expBits = 14'b11111110100101;
        do_reset();
        loadStrobe = 1'b1;
        step();
        loadData = 8'hA5; loadStrobe = 1'b0;
        step();
        enable = 1'b1; divider = 4'd3;
        for (int k = 0; k < 14; k++) begin
            step();
            checkCount++;
            if (pixelOut !== expBits[13 - k]) $display("FAIL div_pixel[%0d]: got %b expected %b", k, pixelOut, expBits[13 - k]);
            else passCount++;
            if (k == 7) divider = 4'd0;
        end
        checkCount++; if (underrun !== 1'b0) $display("FAIL div_no_underrun: got %b expected 0", underrun); else passCount++;
        step();
        checkCount++; if (underrun !== 1'b1) $display("FAIL div_underrun: got %b expected 1", underrun); else passCount++;
        enable = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic_shift();
        test_multibit();
        test_overflow();
        test_push_pop_full();
        test_reset_and_clear();
        test_divider_change();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/video_shifter.md
# video_shifter

Parametrised video pixel serialiser for the SoC video path. It snoops interrupt-time VRAM read cycles on the memory bus and captures the returned bytes into a small FIFO. It then shifts them out as pixels of 1, 2 or 4 bits each, at a programmable number of clocks per pixel. It replaces the fixed 8-bit, divide-by-2, single-register shifter and adds buffering, multi-bit pixels, and underrun/overflow reporting.

## Interface
Parameters:
- `DATA_WIDTH`, 8: width of one captured VRAM word.
- `BPP`, 1: bits per pixel, one of 1, 2, 4. `DATA_WIDTH % BPP == 0` is required.
- `DIV_BITS`, 4: width of the `divider` input.
- `FIFO_DEPTH`, 2: number of word entries; a power of two, at least 2.
- `LOAD_LATENCY`, 1: cycles from `loadStrobe` to valid `loadData`; at least 1.

Ports:
- `clk`, input, 1: the single clock; all state changes on its rising edge.
- `reset`, input, 1: asynchronous, active-low; low clears all state immediately.
- `loadStrobe`, input, 1: qualified VRAM read seen on the bus (read, strobe, ISR, VRAM address).
- `loadData`, input, `DATA_WIDTH`: memory read data bus.
- `enable`, input, 1: display active (sync inactive).
- `divider`, input, `DIV_BITS`: pixel period minus 1, in clocks.
- `clearFlags`, input, 1: synchronous clear of the sticky flags.
- `pixelOut`, output, `BPP`: current pixel, registered.
- `fifoLevel`, output, `$clog2(FIFO_DEPTH)+1`: number of occupied entries.
- `underrun`, output, 1: sticky; set when a word was needed but the FIFO was empty.
- `overflow`, output, 1: sticky; set when a captured word was dropped because the FIFO was full.

## Operation
- **Capture pipeline.**
  - A `LOAD_LATENCY`-stage shift register carries `loadStrobe`.
  - When its last stage is 1, `loadData` is sampled and pushed into the FIFO.
  - Each strobe is independent, so back-to-back strobes capture back-to-back words.
- **FIFO.**
  - Synchronous and first-in first-out; `fifoLevel` reflects pushes and pops registered at the edge.
  - A push while full (and no pop in the same cycle) drops the word and sets `overflow`.
  - A push and a pop in the same cycle while full are both performed; `overflow` is not set.
- **Pixel timer.**
  - `cnt` counts 0..`divider`.
  - A tick occurs when `enable` is high and `cnt == divider`; `cnt` then returns to 0.
  - `divider` is compared live, so a change takes effect on the next comparison.
  - If `cnt > divider` after a change, the next tick occurs once `cnt` wraps at `2^DIV_BITS - 1`.
- **Shifter.**
  - `shreg` is `DATA_WIDTH` bits; `pixelOut` is `shreg[DATA_WIDTH-1 -: BPP]`.
  - `left` counts the pixels remaining in the current word, from `DATA_WIDTH/BPP` down to 0.
- **On a tick:**
  - If `left > 1`: shift `shreg` left by `BPP`, fill with ones, and decrement `left`.
  - Otherwise, if the FIFO is not empty: pop into `shreg` and set `left = DATA_WIDTH/BPP`.
  - Otherwise: set `shreg` to all ones and `left = 0`, and set `underrun`.
  - A pop on an empty FIFO does not bypass a simultaneous push; the pushed word is stored.
- **Enable low.**
  - `cnt` is held at 0, `shreg` is held all ones, and `left = 0`.
  - Capture into the FIFO continues.
  - The first tick after `enable` rises therefore pops a word.
- **Flags.**
  - `clearFlags` clears both flags.
  - A set event in the same cycle as `clearFlags` wins, so the flag stays 1.

## Timing
- **Reset values:**
  - `pixelOut` all ones, `fifoLevel` 0, `underrun` 0, `overflow` 0.
  - `cnt` 0, `left` 0, strobe pipeline 0.
- **Capture:** a strobe at cycle t samples `loadData` at cycle t+`LOAD_LATENCY`. `fifoLevel` increments after that edge.
- **Enable to first pixel:**
  - `enable` rises before edge e; the first tick is at edge e+`divider`.
  - The first data pixel is visible after that edge, i.e. `divider`+1 cycles after `enable` is sampled high.
- **Pixel duration:** each pixel lasts exactly `divider`+1 clocks while `enable` stays high.
- **Enable falling:** `pixelOut` goes all ones one edge after `enable` is sampled low. Words remaining in the FIFO are kept, not flushed.
- **Reset mid-operation:** all state returns to reset values asynchronously, including in-flight strobes and FIFO contents.

## Structure
- One sub-module, `video_fifo`: a parametrised synchronous FIFO (`WIDTH`, `DEPTH`) with full/empty flags and a level output. It uses the same `clk`/`reset`.
- Shared package `video_pkg`:
  - the `BPP` legality check;
  - the fill-value constant (all ones = background);
  - a `pixelsPerWord(DATA_WIDTH, BPP)` function.
- The top level holds the strobe pipeline, pixel timer, shifter and flags.

## Test plan
1. **Basic shift.** Defaults, `divider=1`, `enable=1`; strobe with `loadData=8'hA5` one cycle later. Required: `pixelOut` sequence 1,0,1,0,0,1,0,1, each bit held 2 clocks, then all ones with `underrun=1`.
2. **Multi-bit pixels.** `BPP=2`, `divider=0`, FIFO preloaded with `8'h1B`. Required: pixels 0,1,2,3 on consecutive clocks, then the next word with no gap cycle.
3. **Overflow.** `FIFO_DEPTH=2`, `enable=0`, three strobes. Required: `fifoLevel=2`, `overflow=1`, and the third word absent on later readout.
4. **Simultaneous push and pop.** `fifoLevel=2`, with a push landing on the same edge as a pop tick. Required: level stays 2 and `overflow` stays 0.
5. **Reset and clear.** Assert `reset` low mid-word. Required: outputs return immediately to all ones with level 0. Then pulse `clearFlags` coincident with an underrun event; required: `underrun` remains 1.
6. **Divider change mid-word.** `divider` 3→0 mid-word. Required: after the current tick the pixel period becomes 1 clock, and no pixel is skipped.
